matrix_scan: RTL and testbench
==============================

Name: matrix_scan

Overview:
- Downstream consumer of the glyph ROM stage: takes the seven 8-bit column bitmaps of the current character and drives a 7-column x 8-row LED dot-matrix by time-multiplexed column scanning.
- Latches the glyph once per frame into shadow registers, so a character change mid-frame never tears the displayed image.
- Inserts a programmable dead time at each column switch to suppress ghosting.
- Provides a blank control and a frame-start strobe for the upstream text sequencer.

Parameters:
- CLK_DIV, 1000, clock cycles each column is held; legal range ≥ 2.
- DEAD, 2, cycles at the start of each column during which col_sel is all-zero; must satisfy DEAD < CLK_DIV.
- SEL_ACTIVE_LOW, 0, 1 inverts col_sel at the output pin (the value stored in the output register, before inversion, is unchanged).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- col0 .. col6  in  8 each  glyph column bitmaps; bit0 = top row; stable from the glyph ROM register
- blank  in  1  1 = force display dark; scanning continues
- col_sel  out  7  one-hot column enable; bit i drives column i
- row_data  out  8  row drive pattern for the selected column
- frame_start  out  1  one-cycle pulse when column 0 begins and the shadow registers are reloaded

Behaviour:
- Reset (rst=1 at a clk edge): pcnt=0, col_idx=0, active=0, shadow0..6=0, blank_q=0, col_sel=0, row_data=0, frame_start=0. Reset wins over every other event, including mid-frame.
- Prescaler pcnt counts 0..CLK_DIV-1 and wraps. tick = (pcnt==CLK_DIV-1).
- On tick: pcnt←0.
  - If active==0 or col_idx==6: col_idx←0, shadow_k←col_k for all k (sampled at that edge), active←1, frame_start←1.
  - Otherwise: col_idx←col_idx+1, shadow unchanged.
- frame_start is 0 on every non-wrap cycle; it is high for exactly the one cycle following the reload edge.
- blank_q←blank every cycle, giving blank a 1-cycle latency.
- Output registers are computed from post-edge state:
  - row_data = (active && !blank_q) ? shadow[col_idx] : 0. On the reload edge, row_data equals the just-sampled col0.
  - col_sel = (active && !blank_q && pcnt ≥ DEAD) ? (1<<col_idx) : 0.
- Timing after reset release: first tick after CLK_DIV cycles. Each column is dark for DEAD cycles, then lit for CLK_DIV-DEAD cycles. Frame period = 7*CLK_DIV cycles.
- col_idx never leaves 0..6. col_sel is never more than one-hot.
- Input changes between reload edges have no effect until the next frame_start.
- blank asserted mid-column: outputs go to 0 one cycle later; pcnt and col_idx keep advancing. On deassert, display resumes at the current column and phase.

Decomposition:
- Shared package matrix_pkg: NUM_COLS=7, ROW_W=8, glyph_t as 7 x 8-bit column array, COL_IDX_W=3. The glyph ROM stage uses the same package.
- One sub-module, scan_prescaler (parameter CLK_DIV; ports clk, rst, tick, pcnt), instantiated once. Column sequencing, shadow storage and output registers live in matrix_scan.

Test Plan:
- Reset and first frame: CLK_DIV=4, DEAD=1, col1=8'h3E, rst held 3 cycles then released → first tick at the 4th edge; frame_start high 1 cycle. At the reload edge row_data=col0, col_sel=0 for 1 cycle, then 7'b0000001 for 3 cycles. Next column shows row_data=8'h3E, col_sel=7'b0000010.
- Full scan and wrap: glyph "8" (col1..5 = 36,49,49,49,36 hex) → col_sel walks bits 0..6. frame_start recurs every 28 cycles. row_data per column matches the glyph.
- No tearing: change col0..6 from "0" to "1" at mid-column 3 → the current frame completes with "0" data. "1" data appears only from the next frame_start.
- Blank: assert blank for 5 cycles in column 2 → col_sel and row_data are 0 starting one cycle after assertion. After release, col_idx continues unchanged; no frame_start is skipped.
- Reset mid-frame: assert rst during column 4 → next cycle all outputs are 0 and active=0. After release, the sequence restarts exactly as in scenario 1.
- SEL_ACTIVE_LOW=1 → pin value is the inverse (7'b1111110 while column 0 is lit, 7'b1111111 during dead time and reset).

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types for the glyph path: the glyph ROM stage and the matrix scanner
// both speak in glyph_t (seven 8-bit column bitmaps, bit0 = top row).
package matrix_pkg;

    localparam int NUM_COLS  = 7;
    localparam int ROW_W     = 8;
    localparam int COL_IDX_W = 3;

    typedef logic [ROW_W-1:0]                 col_bits_t;
    typedef logic [NUM_COLS-1:0][ROW_W-1:0]   glyph_t;

    function automatic logic [NUM_COLS-1:0] col_onehot(input logic [COL_IDX_W-1:0] idx);
        logic [NUM_COLS-1:0] one;
        one = NUM_COLS'(1);
        return one << idx;
    endfunction

endpackage

// File: rtl/matrix_scan_if.sv
// Glyph-in / LED-drive-out bundle between the text sequencer side and the scanner.
interface matrix_scan_if;
    import matrix_pkg::*;

    col_bits_t           col0, col1, col2, col3, col4, col5, col6;
    logic                blank;
    logic [NUM_COLS-1:0] col_sel;
    col_bits_t           row_data;
    logic                frame_start;

    modport master (
        output col0, col1, col2, col3, col4, col5, col6, blank,
        input  col_sel, row_data, frame_start
    );

    modport slave (
        input  col0, col1, col2, col3, col4, col5, col6, blank,
        output col_sel, row_data, frame_start
    );

endinterface

// File: rtl/matrix_scan_prescaler.sv
// Column-hold prescaler: free-running 0..CLK_DIV-1 counter, tick on the last count.
module scan_prescaler #(
    parameter int CLK_DIV = 1000,
    parameter int PCNT_W  = $clog2(CLK_DIV)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              tick,
    output logic [PCNT_W-1:0] pcnt
);

    assign tick = (pcnt == PCNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PCNT_W'(1);
        end
    end

endmodule

// File: rtl/matrix_scan.sv
// 7x8 LED dot-matrix column scanner with per-frame glyph shadowing, column
// dead time against ghosting, and a blank control.
module matrix_scan
    import matrix_pkg::*;
#(
    parameter int CLK_DIV        = 1000,
    parameter int DEAD           = 2,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    matrix_scan_if.slave bus
);

    localparam int                   PCNT_W   = $clog2(CLK_DIV);
    localparam logic [PCNT_W-1:0]    DEAD_CNT = PCNT_W'(DEAD);
    localparam logic [COL_IDX_W-1:0] LAST_COL = COL_IDX_W'(NUM_COLS - 1);

    logic                 tick;
    logic [PCNT_W-1:0]    pcnt;
    logic [PCNT_W-1:0]    pcnt_nxt;
    logic [COL_IDX_W-1:0] col_idx;
    logic [COL_IDX_W-1:0] col_idx_nxt;
    logic                 active;
    logic                 reload;
    glyph_t               glyph_in;
    glyph_t               shadow;
    glyph_t               shadow_nxt;
    col_bits_t            row_nxt;
    col_bits_t            row_q;
    logic [NUM_COLS-1:0]  sel_q;
    logic                 fs_q;

    scan_prescaler #(
        .CLK_DIV (CLK_DIV),
        .PCNT_W  (PCNT_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .pcnt (pcnt)
    );

    assign glyph_in = {bus.col6, bus.col5, bus.col4, bus.col3, bus.col2, bus.col1, bus.col0};

    // A frame starts on the very first tick after reset and after the last column.
    assign reload = tick && (!active || (col_idx == LAST_COL));

    // Outputs are registered from the state the edge is about to load, so the
    // drive pins never show a decode glitch and the shadow reload is visible at once.
    always_comb begin
        pcnt_nxt    = tick ? '0 : pcnt + PCNT_W'(1);
        col_idx_nxt = col_idx;
        shadow_nxt  = shadow;
        if (reload) begin
            col_idx_nxt = '0;
            shadow_nxt  = glyph_in;
        end else if (tick) begin
            col_idx_nxt = col_idx + COL_IDX_W'(1);
        end
        row_nxt = '0;
        for (int k = 0; k < NUM_COLS; k++) begin
            if (col_idx_nxt == COL_IDX_W'(k)) begin
                row_nxt = shadow_nxt[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_idx <= '0;
            active  <= 1'b0;
            shadow  <= '0;
            row_q   <= '0;
            sel_q   <= '0;
            fs_q    <= 1'b0;
        end else begin
            col_idx <= col_idx_nxt;
            shadow  <= shadow_nxt;
            active  <= active | reload;
            fs_q    <= reload;
            // blank is taken straight into the output registers: one cycle of latency.
            if ((active || reload) && !bus.blank) begin
                row_q <= row_nxt;
                sel_q <= (pcnt_nxt >= DEAD_CNT) ? col_onehot(col_idx_nxt) : '0;
            end else begin
                row_q <= '0;
                sel_q <= '0;
            end
        end
    end

    assign bus.col_sel     = sel_q ^ {NUM_COLS{SEL_ACTIVE_LOW}};
    assign bus.row_data    = row_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_matrix_scan.sv
// Self-checking bench for matrix_scan: two instances (active-high and active-low
// col_sel) fed the same glyph/blank, compared against a frame/phase arithmetic model.
module tb_matrix_scan;
    import matrix_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int DEAD    = 1;
    localparam int NC      = 7;
    localparam int FRAME   = NC * CLK_DIV;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   blank = 1'b0;
    glyph_t glyph = '0;

    int checks = 0;
    int errors = 0;

    matrix_scan_if ifa ();
    matrix_scan_if ifb ();

    assign {ifa.col6, ifa.col5, ifa.col4, ifa.col3, ifa.col2, ifa.col1, ifa.col0} = glyph;
    assign {ifb.col6, ifb.col5, ifb.col4, ifb.col3, ifb.col2, ifb.col1, ifb.col0} = glyph;
    assign ifa.blank = blank;
    assign ifb.blank = blank;

    matrix_scan #(.CLK_DIV(CLK_DIV), .DEAD(DEAD), .SEL_ACTIVE_LOW(1'b0)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa.slave)
    );
    matrix_scan #(.CLK_DIV(CLK_DIV), .DEAD(DEAD), .SEL_ACTIVE_LOW(1'b1)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb.slave)
    );

    always #5 clk = ~clk;

    // Reference: n = edges since reset release; the schedule follows from n alone.
    int        n = 0;
    int        m_col = 0;
    int        m_phase = 0;
    bit        m_active = 0;
    glyph_t    m_shadow = '0;
    logic [6:0] exp_sel = '0;
    logic [7:0] exp_row = '0;
    logic       exp_fs  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            n = 0; m_active = 0; m_col = 0; m_phase = 0;
            m_shadow = '0; exp_sel = '0; exp_row = '0; exp_fs = 1'b0;
        end else begin
            n++;
            m_active = (n >= CLK_DIV);
            m_phase  = n % CLK_DIV;
            m_col    = m_active ? ((n / CLK_DIV) - 1) % NC : 0;
            exp_fs   = m_active && (m_col == 0) && (m_phase == 0);
            if (exp_fs) m_shadow = glyph;
            exp_row  = (m_active && !blank) ? m_shadow[m_col] : 8'h00;
            exp_sel  = (m_active && !blank && m_phase >= DEAD) ? 7'(1 << m_col) : 7'h00;
        end
    end

    task automatic test_reset();
        rst = 1'b1; blank = 1'b0;
        glyph = '0; glyph[0] = 8'h81; glyph[1] = 8'h3E;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({ifa.col_sel, ifa.row_data, ifa.frame_start} !== 16'h0000 || ifb.col_sel !== 7'h7F) begin
                errors++;
                $display("FAIL reset cyc%0d: sel=%b row=%h fs=%b pin_lo=%b, want all zero, pin_lo=1111111",
                         i, ifa.col_sel, ifa.row_data, ifa.frame_start, ifb.col_sel);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_first_frame(input string tag);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            checks++;
            if ({ifa.col_sel, ifa.row_data, ifa.frame_start} !== {exp_sel, exp_row, exp_fs}) begin
                errors++;
                $display("FAIL %s model e%0d: sel=%b row=%h fs=%b want sel=%b row=%h fs=%b",
                         tag, i, ifa.col_sel, ifa.row_data, ifa.frame_start, exp_sel, exp_row, exp_fs);
            end
            if (i == 4) begin
                checks++;
                if (ifa.frame_start !== 1'b1 || ifa.row_data !== glyph[0] || ifa.col_sel !== 7'b0) begin
                    errors++;
                    $display("FAIL %s reload: fs=%b row=%h sel=%b want fs=1 row=%h sel=0000000",
                             tag, ifa.frame_start, ifa.row_data, ifa.col_sel, glyph[0]);
                end
            end
            if (i == 5) begin
                checks++;
                if (ifa.col_sel !== 7'b0000001 || ifb.col_sel !== 7'b1111110 || ifa.frame_start !== 1'b0) begin
                    errors++;
                    $display("FAIL %s col0_lit: sel=%b pin_lo=%b fs=%b want 0000001 1111110 0",
                             tag, ifa.col_sel, ifb.col_sel, ifa.frame_start);
                end
            end
            if (i == 8) begin
                checks++;
                if (ifa.row_data !== 8'h3E || ifa.col_sel !== 7'b0) begin
                    errors++;
                    $display("FAIL %s col1_dead: row=%h sel=%b want 3e 0000000", tag, ifa.row_data, ifa.col_sel);
                end
            end
            if (i == 9) begin
                checks++;
                if (ifa.col_sel !== 7'b0000010 || ifa.row_data !== 8'h3E) begin
                    errors++;
                    $display("FAIL %s col1_lit: sel=%b row=%h want 0000010 3e", tag, ifa.col_sel, ifa.row_data);
                end
            end
        end
    endtask

    task automatic test_full_scan();
        int last_fs = -1;
        int nfs = 0;
        glyph = {8'h00, 8'h36, 8'h49, 8'h49, 8'h49, 8'h36, 8'h00};
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({ifa.col_sel, ifa.row_data, ifa.frame_start} !== {exp_sel, exp_row, exp_fs}
                || ifb.col_sel !== ~exp_sel) begin
                errors++;
                $display("FAIL scan c%0d: sel=%b row=%h fs=%b pin_lo=%b want sel=%b row=%h fs=%b",
                         i, ifa.col_sel, ifa.row_data, ifa.frame_start, ifb.col_sel, exp_sel, exp_row, exp_fs);
            end
            if (ifa.frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (i - last_fs != FRAME) begin
                        errors++;
                        $display("FAIL frame_period: got %0d want %0d", i - last_fs, FRAME);
                    end
                end
                last_fs = i;
                nfs++;
            end
        end
        checks++;
        if (nfs < 3) begin
            errors++;
            $display("FAIL frame_count: got %0d frame_start pulses want 3", nfs);
        end
    endtask

    task automatic test_no_tearing();
        glyph_t g_zero = {8'h00, 8'h3E, 8'h45, 8'h49, 8'h51, 8'h3E, 8'h00};
        glyph_t g_one  = {8'h00, 8'h00, 8'h40, 8'h7F, 8'h42, 8'h00, 8'h00};
        int  cyc = 0;
        bit  seen_fs = 0;
        bit  old_frame = 1;
        glyph = g_zero;
        while (!(seen_fs && m_col == 3 && m_phase == 2) && cyc < 3 * FRAME) begin
            @(negedge clk);
            cyc++;
            if (exp_fs) seen_fs = 1;
        end
        checks++;
        if (cyc >= 3 * FRAME) begin
            errors++;
            $display("FAIL tear_sync: timeout after %0d cycles, want mid column 3", cyc);
        end
        glyph = g_one;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (ifa.frame_start === 1'b1) old_frame = 0;
            checks++;
            if ({ifa.col_sel, ifa.row_data, ifa.frame_start} !== {exp_sel, exp_row, exp_fs}) begin
                errors++;
                $display("FAIL tear c%0d: sel=%b row=%h fs=%b want sel=%b row=%h fs=%b",
                         i, ifa.col_sel, ifa.row_data, ifa.frame_start, exp_sel, exp_row, exp_fs);
            end
            if (old_frame && m_col >= 3) begin
                checks++;
                if (ifa.row_data !== g_zero[m_col]) begin
                    errors++;
                    $display("FAIL tear_old col%0d: row=%h want %h", m_col, ifa.row_data, g_zero[m_col]);
                end
            end
            if (!old_frame) begin
                checks++;
                if (ifa.row_data !== g_one[m_col]) begin
                    errors++;
                    $display("FAIL tear_new col%0d: row=%h want %h", m_col, ifa.row_data, g_one[m_col]);
                end
            end
        end
    endtask

    task automatic test_blank();
        int cyc = 0;
        int nfs = 0;
        glyph[2] = 8'h5A;
        while (!(m_col == 2 && m_phase == 1) && cyc < 2 * FRAME) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 2 * FRAME) begin
            errors++;
            $display("FAIL blank_sync: timeout after %0d cycles", cyc);
        end
        blank = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ifa.col_sel !== 7'b0 || ifa.row_data !== 8'h00 || ifb.col_sel !== 7'h7F || m_col != 2 + (i + 2) / CLK_DIV) begin
                errors++;
                $display("FAIL blank c%0d: sel=%b row=%h pin_lo=%b want dark", i, ifa.col_sel, ifa.row_data, ifb.col_sel);
            end
        end
        blank = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (ifa.frame_start === 1'b1) nfs++;
            checks++;
            if ({ifa.col_sel, ifa.row_data, ifa.frame_start} !== {exp_sel, exp_row, exp_fs}) begin
                errors++;
                $display("FAIL unblank c%0d: sel=%b row=%h fs=%b want sel=%b row=%h fs=%b",
                         i, ifa.col_sel, ifa.row_data, ifa.frame_start, exp_sel, exp_row, exp_fs);
            end
        end
        checks++;
        if (nfs != 1) begin
            errors++;
            $display("FAIL blank_fs: got %0d frame_start pulses in one frame want 1", nfs);
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        while (!(m_col == 4 && m_phase == 2) && cyc < 2 * FRAME) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 2 * FRAME) begin
            errors++;
            $display("FAIL rst_mid_sync: timeout after %0d cycles", cyc);
        end
        glyph = '0; glyph[0] = 7'($urandom_range(1, 127)); glyph[1] = 8'h3E;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ifa.col_sel, ifa.row_data, ifa.frame_start} !== 16'h0000 || ifb.col_sel !== 7'h7F
            || dut_a.active !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: sel=%b row=%h fs=%b pin_lo=%b active=%b want all zero, pin_lo=1111111",
                     ifa.col_sel, ifa.row_data, ifa.frame_start, ifb.col_sel, dut_a.active);
        end
        rst = 1'b0;
        test_first_frame("restart");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if ({ifa.col_sel, ifa.row_data, ifa.frame_start} !== {exp_sel, exp_row, exp_fs}
                || ifb.col_sel !== ~exp_sel) begin
                errors++;
                $display("FAIL rand c%0d: sel=%b row=%h fs=%b pin_lo=%b want sel=%b row=%h fs=%b",
                         i, ifa.col_sel, ifa.row_data, ifa.frame_start, ifb.col_sel, exp_sel, exp_row, exp_fs);
            end
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < NC; k++) glyph[k] = 8'($urandom);
            end
            if ($urandom_range(0, 9) == 0) blank = ~blank;
        end
        blank = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_frame("first");
        test_full_scan();
        test_no_tearing();
        test_blank();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
